hash_bits_off_sequencer: RTL and testbench
==========================================

HASH_BITS_OFF_SEQUENCER -- requirements
Module: hash_bits_off_sequencer

Interface
REQ-001 The block SHALL have a parameter HASH_BITS, default 1024, giving the XOR vector width; only 1024 is supported, and the widths of count_i and score_o are fixed to match it.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit: request to score hash_xor_i.
REQ-005 The block SHALL have port abort_i, input, 1 bit: cancel the scoring in progress.
REQ-006 The block SHALL have port clear_best_i, input, 1 bit: set the best score back to its initial value.
REQ-007 The block SHALL have port hash_xor_i, input, HASH_BITS wide: hash XOR target, sampled on an accepted start.
REQ-008 The block SHALL have port count_i, input, 10 bits: current value of the external bits-off counter register.
REQ-009 The block SHALL have port count_reset_o, output, 1 bit: clear command to the counter.
REQ-010 The block SHALL have port count_add_o, output, 1 bit: add enable to the counter.
REQ-011 The block SHALL have port count_bit_o, output, 1 bit: the XOR bit the counter adds.
REQ-012 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port score_o, output, 11 bits: final bits-off count of the last completed run.
REQ-015 The block SHALL have port new_best_o, output, 1 bit: the last run improved the best score; valid with done_o.
REQ-016 The block SHALL have port best_score_o, output, 11 bits: lowest score seen so far.

Function
REQ-017 The block SHALL implement the states IDLE, CLEAR, SHIFT, COMPARE and DONE.
REQ-018 In IDLE, start_i=1 SHALL latch hash_xor_i into an internal register and move to CLEAR; start_i SHALL be ignored in every other state.
REQ-019 CLEAR SHALL last one cycle, drive count_reset_o=1 and count_add_o=0, zero the bit index and the overflow flag, then move to SHIFT.
REQ-020 SHIFT SHALL last exactly HASH_BITS cycles: count_add_o=1, count_bit_o=latched[k] in the k-th SHIFT cycle, k=0..1023, LSB first.
REQ-021 After the cycle with k=1023, the block SHALL move to COMPARE.
REQ-022 The overflow flag SHALL be set when, in SHIFT, count_add_o=1, count_bit_o=1 and count_i=10'd1023; this is the case in which the 10-bit counter wraps to 0.
REQ-023 COMPARE SHALL last one cycle and register score_o={overflow flag, count_i}, so that all-ones input yields 11'd1024.
REQ-024 COMPARE SHALL register new_best_o=(score < best_score_o) and, when that comparison is true, update best_score_o to the score.
REQ-025 DONE SHALL drive done_o=1 for exactly one cycle, then return to IDLE; score_o, new_best_o and best_score_o SHALL hold until the next COMPARE or reset.
REQ-026 Latency: a start sampled at edge T SHALL give CLEAR in cycle T+1, SHIFT in T+2..T+1025, COMPARE in T+1026 and done_o=1 in T+1027.
REQ-027 abort_i=1 in CLEAR, SHIFT or COMPARE SHALL force IDLE on the next edge, with no done_o and no update to score_o, new_best_o or best_score_o; abort_i SHALL have no effect in IDLE or DONE.
REQ-028 clear_best_i=1 SHALL set best_score_o to 11'h7FF on the next edge; if it coincides with COMPARE, clear_best_i SHALL win and new_best_o SHALL still reflect the comparison made before the clear.
REQ-029 Outside CLEAR and SHIFT, count_reset_o, count_add_o and count_bit_o SHALL be 0.

Reset
REQ-030 reset_i=1 SHALL, on the next edge, set state=IDLE, busy_o=0, done_o=0, new_best_o=0, score_o=0 and best_score_o=11'h7FF, and clear the overflow flag and the bit index.
REQ-031 While reset_i=1, count_reset_o SHALL be 1 and count_add_o SHALL be 0, so the counter clears together with the controller.
REQ-032 Reset asserted mid-run SHALL abandon the run, with no done_o pulse.

Verification
REQ-033 The bench SHALL cover: hash_xor_i=0 -> done_o at T+1027, score_o=0, new_best_o=1, best_score_o=0.
REQ-034 The bench SHALL cover: hash_xor_i with 381 ones, then a second start with 400 ones -> first run score 381 with new_best_o=1; second run score 400, new_best_o=0, best_score_o stays 381.
REQ-035 The bench SHALL cover: hash_xor_i all ones -> counter wraps to 0 and score_o=11'd1024.
REQ-036 The bench SHALL cover: abort_i at SHIFT k=500 -> IDLE next cycle, no done_o, score_o and best_score_o unchanged; start_i pulsed while busy -> ignored.
REQ-037 The bench SHALL cover: clear_best_i asserted in the COMPARE cycle of a run scoring 10 -> new_best_o=1, best_score_o=11'h7FF afterwards.
REQ-038 The bench SHALL cover: reset_i at SHIFT k=200 -> all outputs at reset values, count_reset_o=1 while reset_i is high, and a fresh run afterwards scores correctly.

Source files
------------

// File: rtl/hash_bits_off_sequencer.sv
// Hash bits-off scoring sequencer.
// Drives an external 10-bit counter, one XOR bit per cycle, and tracks the best score.
//
// Ports:
//   clk_i         clock, rising edge
//   reset_i       synchronous active-high reset
//   start_i       score hash_xor_i (accepted in IDLE only)
//   abort_i       cancel the run (CLEAR/SHIFT/COMPARE)
//   clear_best_i  best_score_o back to 11'h7FF
//   hash_xor_i    XOR vector, latched on an accepted start
//   count_i       external counter value
//   count_reset_o counter clear
//   count_add_o   counter add enable
//   count_bit_o   bit added to the counter
//   busy_o        not IDLE
//   done_o        one-cycle completion pulse
//   score_o       {overflow, count} of last completed run
//   new_best_o    last run improved best score
//   best_score_o  lowest score seen

module hash_bits_off_sequencer #(
  parameter int HASH_BITS = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 clear_best_i,
  input  logic [HASH_BITS-1:0] hash_xor_i,
  input  logic [9:0]           count_i,
  output logic                 count_reset_o,
  output logic                 count_add_o,
  output logic                 count_bit_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [10:0]          score_o,
  output logic                 new_best_o,
  output logic [10:0]          best_score_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [9:0]  IDX_LAST  = 10'(HASH_BITS - 1);
  localparam logic [9:0]  CNT_MAX   = 10'h3FF;
  localparam logic [10:0] BEST_INIT = 11'h7FF;

  state_t r_state;
  state_t w_next;

  logic [HASH_BITS-1:0] r_xor;
  logic [9:0]           r_idx;
  logic                 r_ovf;
  logic [10:0]          r_score;
  logic                 r_new_best;
  logic [10:0]          r_best;

  logic        w_latch;
  logic        w_clr_idx;
  logic        w_step;
  logic        w_cmp;
  logic        w_cnt_rst;
  logic        w_cnt_add;
  logic        w_cnt_bit;
  logic        w_busy;
  logic        w_done;
  logic [10:0] w_score;
  logic        w_better;
  logic        w_wrap;

  // Score is the counter extended by the wrap flag,
  // so an all-ones vector reads 1024 instead of 0.
  assign w_score  = {r_ovf, count_i};
  assign w_better = (w_score < r_best);

  // The counter is about to roll over from 1023 to 0.
  assign w_wrap = w_cnt_add && w_cnt_bit &&
                  (count_i == CNT_MAX);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_clr_idx = 1'b0;
    w_step    = 1'b0;
    w_cmp     = 1'b0;
    w_cnt_rst = 1'b0;
    w_cnt_add = 1'b0;
    w_cnt_bit = 1'b0;
    w_busy    = 1'b1;
    w_done    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start_i) begin
          w_latch = 1'b1;
          w_next  = S_CLEAR;
        end
      end

      S_CLEAR: begin
        w_cnt_rst = 1'b1;
        w_clr_idx = 1'b1;
        if (abort_i) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_cnt_add = 1'b1;
        w_cnt_bit = r_xor[r_idx];
        w_step    = 1'b1;
        if (abort_i) begin
          w_next = S_IDLE;
        end else if (r_idx == IDX_LAST) begin
          w_next = S_COMPARE;
        end
      end

      S_COMPARE: begin
        if (abort_i) begin
          w_next = S_IDLE;
        end else begin
          w_cmp  = 1'b1;
          w_next = S_DONE;
        end
      end

      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Hold the counter cleared alongside the controller.
    if (reset_i) begin
      w_cnt_rst = 1'b1;
      w_cnt_add = 1'b0;
      w_cnt_bit = 1'b0;
      w_latch   = 1'b0;
      w_step    = 1'b0;
      w_cmp     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_latch) begin
      r_xor <= hash_xor_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_idx <= '0;
      r_ovf <= 1'b0;
    end else if (w_clr_idx) begin
      r_idx <= '0;
      r_ovf <= 1'b0;
    end else if (w_step) begin
      r_idx <= r_idx + 10'd1;
      if (w_wrap) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_score    <= '0;
      r_new_best <= 1'b0;
      r_best     <= BEST_INIT;
    end else begin
      if (w_cmp) begin
        r_score    <= w_score;
        r_new_best <= w_better;
        if (w_better) begin
          r_best <= w_score;
        end
      end
      // Clearing overrides a same-cycle improvement;
      // new_best_o still reports the comparison.
      if (clear_best_i) begin
        r_best <= BEST_INIT;
      end
    end
  end

  assign count_reset_o = w_cnt_rst;
  assign count_add_o   = w_cnt_add;
  assign count_bit_o   = w_cnt_bit;
  assign busy_o        = w_busy;
  assign done_o        = w_done;
  assign score_o       = r_score;
  assign new_best_o    = r_new_best;
  assign best_score_o  = r_best;

endmodule

// File: tb/tb_hash_bits_off_sequencer.sv
// Bench for hash_bits_off_sequencer.
// Models the external 10-bit counter; table vectors plus corner sequences.

module tb_hash_bits_off_sequencer;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic          abort_i;
  logic          clear_best_i;
  logic [1023:0] hash_xor_i;
  logic [9:0]    count_i;
  logic          count_reset_o;
  logic          count_add_o;
  logic          count_bit_o;
  logic          busy_o;
  logic          done_o;
  logic [10:0]   score_o;
  logic          new_best_o;
  logic [10:0]   best_score_o;

  int n_pass = 0;
  int n_tot  = 0;

  hash_bits_off_sequencer #(.HASH_BITS(1024)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .clear_best_i (clear_best_i),
    .hash_xor_i   (hash_xor_i),
    .count_i      (count_i),
    .count_reset_o(count_reset_o),
    .count_add_o  (count_add_o),
    .count_bit_o  (count_bit_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .score_o      (score_o),
    .new_best_o   (new_best_o),
    .best_score_o (best_score_o)
  );

  always #5 clk_i = ~clk_i;

  // External bits-off counter.
  logic [9:0] r_cnt;
  always @(posedge clk_i) begin
    if (count_reset_o) r_cnt <= '0;
    else if (count_add_o) r_cnt <= r_cnt + {9'd0, count_bit_o};
  end
  assign count_i = r_cnt;

  typedef struct {
    int          ones;
    int          stride;
    bit          clr;
    logic [10:0] score;
    logic        nb;
    logic [10:0] best;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else
      n_pass++;
  endtask

  // Odd stride is coprime with 1024, so positions are distinct.
  function automatic logic [1023:0] mk(int ones, int stride);
    logic [1023:0] v;
    v = '0;
    for (int i = 0; i < ones; i++) v[(i * stride) % 1024] = 1'b1;
    return v;
  endfunction

  // Interval n after the accepting edge: 0=CLEAR, 1..1024=SHIFT k=n-1,
  // 1025=COMPARE, 1026=DONE. done_n returns the cycle label n+1.
  task automatic go(input logic [1023:0] x,
                    input int abort_n,
                    input int clr_n,
                    input int rst_n,
                    input int spur_n,
                    output int done_n);
    int bad;
    int stop_n;
    int last_n;
    bad    = 0;
    done_n = -1;
    stop_n = -1;
    if (abort_n >= 0) stop_n = abort_n;
    if (rst_n >= 0) stop_n = rst_n;
    last_n = (stop_n >= 0) ? stop_n : 1024;
    @(negedge clk_i);
    hash_xor_i = x;
    start_i    = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i    = 1'b0;
    hash_xor_i = ~x;
    for (int n = 0; n < 1100; n++) begin
      if (n > 0) @(negedge clk_i);
      abort_i      = 1'b0;
      clear_best_i = 1'b0;
      start_i      = 1'b0;
      if (stop_n >= 0 && n == stop_n + 1) break;
      if (n == 0)
        chk("clear_cyc", 32'({count_reset_o, count_add_o}), 32'd2);
      if (n >= 1 && n <= 1024 && n <= last_n) begin
        if (count_add_o !== 1'b1 || count_bit_o !== x[n-1]) bad++;
      end
      if (done_o === 1'b1) begin
        done_n = n + 1;
        break;
      end
      if (n == abort_n) abort_i = 1'b1;
      if (n == clr_n) clear_best_i = 1'b1;
      if (n == spur_n) start_i = 1'b1;
      if (n == rst_n) begin
        reset_i = 1'b1;
        #1;
        chk("rst_cnt_comb", 32'({count_reset_o, count_add_o}), 32'd2);
      end
    end
    chk("bitseq", 32'(bad), 32'd0);
  endtask

  int d;
  int nd;
  logic [10:0] p_score;
  logic [10:0] p_best;
  logic        p_nb;

  initial begin
    tbl[0] = '{381,  7,  1'b0, 11'd381,  1'b1, 11'd381};
    tbl[1] = '{400,  13, 1'b0, 11'd400,  1'b0, 11'd381};
    tbl[2] = '{1024, 1,  1'b0, 11'd1024, 1'b0, 11'd381};
    tbl[3] = '{0,    1,  1'b0, 11'd0,    1'b1, 11'd0};
    tbl[4] = '{5,    3,  1'b0, 11'd5,    1'b0, 11'd0};
    tbl[5] = '{700,  11, 1'b1, 11'd700,  1'b1, 11'd700};
    tbl[6] = '{1023, 1,  1'b0, 11'd1023, 1'b0, 11'd700};
    tbl[7] = '{701,  5,  1'b0, 11'd701,  1'b0, 11'd700};

    reset_i      = 1'b1;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    clear_best_i = 1'b0;
    hash_xor_i   = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_score", 32'(score_o), 32'd0);
    chk("rst_nb", 32'(new_best_o), 32'd0);
    chk("rst_best", 32'(best_score_o), 32'h7FF);
    chk("rst_cnt", 32'({count_reset_o, count_add_o}), 32'd2);
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("idle_cnt",
        32'({count_reset_o, count_add_o, count_bit_o}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].clr) begin
        clear_best_i = 1'b1;
        @(negedge clk_i);
        clear_best_i = 1'b0;
        chk("clr_idle", 32'(best_score_o), 32'h7FF);
      end
      go(mk(tbl[i].ones, tbl[i].stride), -1, -1, -1, -1, d);
      chk("done_lat", 32'(d), 32'd1027);
      chk("score", 32'(score_o), 32'(tbl[i].score));
      chk("new_best", 32'(new_best_o), 32'(tbl[i].nb));
      chk("best", 32'(best_score_o), 32'(tbl[i].best));
      @(negedge clk_i);
      chk("done_pulse", 32'({done_o, busy_o}), 32'd0);
    end

    // Abort at SHIFT k=500, with a stray start at k=100.
    p_score = score_o;
    p_best  = best_score_o;
    p_nb    = new_best_o;
    go(mk(300, 3), 501, -1, -1, 101, d);
    chk("abort_idle", 32'({busy_o, done_o}), 32'd0);
    nd = 0;
    repeat (1100) begin
      @(negedge clk_i);
      if (done_o !== 1'b0) nd++;
    end
    chk("abort_nodone", 32'(nd), 32'd0);
    chk("abort_score", 32'(score_o), 32'(p_score));
    chk("abort_best", 32'(best_score_o), 32'(p_best));
    chk("abort_nb", 32'(new_best_o), 32'(p_nb));

    // clear_best_i in the COMPARE cycle of a run scoring 10.
    go(mk(10, 17), -1, 1025, -1, -1, d);
    chk("cb_lat", 32'(d), 32'd1027);
    chk("cb_score", 32'(score_o), 32'd10);
    chk("cb_nb", 32'(new_best_o), 32'd1);
    chk("cb_best", 32'(best_score_o), 32'h7FF);

    go(mk(20, 3), -1, -1, -1, -1, d);
    chk("pre_rst_best", 32'(best_score_o), 32'd20);

    // Reset at SHIFT k=200.
    go(mk(300, 5), -1, -1, 201, -1, d);
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_done", 32'(done_o), 32'd0);
    chk("mr_score", 32'(score_o), 32'd0);
    chk("mr_nb", 32'(new_best_o), 32'd0);
    chk("mr_best", 32'(best_score_o), 32'h7FF);
    chk("mr_cnt", 32'({count_reset_o, count_add_o}), 32'd2);
    @(negedge clk_i);
    chk("mr_cnt2", 32'({count_reset_o, count_add_o}), 32'd2);
    reset_i = 1'b0;
    @(negedge clk_i);
    go(mk(50, 9), -1, -1, -1, -1, d);
    chk("post_lat", 32'(d), 32'd1027);
    chk("post_score", 32'(score_o), 32'd50);
    chk("post_nb", 32'(new_best_o), 32'd1);
    chk("post_best", 32'(best_score_o), 32'd50);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
